// File: rtl/pipe_pkg.sv
// Types and constants shared by the fetch stage and the decode side of the pipeline.
package pipe_pkg;

  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StWait  = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // PC field is sized for the widest supported PC; narrower PCs are zero-extended.
  localparam int unsigned IF_ID_PC_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [IF_ID_PC_W-1:0] pc;
    logic [31:0]           instr;
  } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: sync reset, word-aligned redirect load, wrapping +4 increment.
module pc_reg #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_inc,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_pc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_target;

  assign w_target = i_redirect_pc & ~PC_W'(3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= w_target;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(4);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, IF/ID register with stall hold
// buffer, and redirect flush that drains any response to the old PC.
module fetch_unit #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [6:0]      id_opcode
);
  import pipe_pkg::*;

  localparam if_id_t Bubble = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};

  fetch_state_t    r_state;
  if_id_t          r_ifid;
  logic            r_hold_vld;
  logic [31:0]     r_hold_instr;
  logic [PC_W-1:0] w_pc;
  logic            w_load_mem;
  logic            w_load_hold;
  logic            w_inc;

  assign w_load_mem  = (r_state == StWait) && imem_rvalid && !redirect && !stall;
  assign w_load_hold = (r_state == StHold) && r_hold_vld && !redirect && !stall;
  assign w_inc       = w_load_mem || w_load_hold;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .i_inc         (w_inc),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_pc          (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StReq;
      r_ifid       <= Bubble;
      r_hold_vld   <= 1'b0;
      r_hold_instr <= NOP_INSTR;
    end else if (redirect) begin
      r_ifid     <= Bubble;
      r_hold_vld <= 1'b0;
      // A response arriving this cycle closes the outstanding read, so no drain is needed.
      unique case (r_state)
        StReq:   r_state <= StDrain;
        StWait:  r_state <= imem_rvalid ? StReq : StDrain;
        StHold:  r_state <= StReq;
        StDrain: r_state <= imem_rvalid ? StReq : StDrain;
        default: r_state <= StReq;
      endcase
    end else begin
      if (w_load_mem) begin
        r_ifid <= '{valid: 1'b1, pc: IF_ID_PC_W'(w_pc), instr: imem_rdata};
      end else if (w_load_hold) begin
        r_ifid <= '{valid: 1'b1, pc: IF_ID_PC_W'(w_pc), instr: r_hold_instr};
      end else if (!stall) begin
        r_ifid <= Bubble;
      end

      unique case (r_state)
        StReq: r_state <= StWait;
        StWait: begin
          if (imem_rvalid) begin
            if (stall) begin
              r_hold_vld   <= 1'b1;
              r_hold_instr <= imem_rdata;
              r_state      <= StHold;
            end else begin
              r_state <= StReq;
            end
          end
        end
        StHold: begin
          if (!stall) begin
            r_hold_vld <= 1'b0;
            r_state    <= StReq;
          end
        end
        StDrain: begin
          if (imem_rvalid) begin
            r_state <= StReq;
          end
        end
        default: r_state <= StReq;
      endcase
    end
  end

  assign imem_req  = (r_state == StReq) && !reset;
  assign imem_addr = w_pc;
  assign id_valid  = r_ifid.valid;
  assign id_pc     = r_ifid.pc[PC_W-1:0];
  assign id_instr  = r_ifid.instr;
  assign id_opcode = r_ifid.instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays a 1-cycle instruction memory by hand.
module tb_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_opcode   (id_opcode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
    check({tag, ".valid"}, 32'(id_valid), 32'(v));
    if (v) check({tag, ".pc"}, id_pc, pc);
    check({tag, ".instr"}, id_instr, instr);
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".req"}, 32'(imem_req), 32'(req));
    if (req) check({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    reset       = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    tick();
    check_req("rst.gate", 1'b0, 32'h0);
    check("rst.valid", 32'(id_valid), 32'h0);
    check("rst.pc", id_pc, 32'h0);
    check("rst.instr", id_instr, Nop);
    reset = 1'b0;
    #1;

    // Cycle 0: REQ at RESET_PC
    check_req("c0", 1'b1, 32'h0);
    tick();
    // Cycle 1: WAIT, memory answers
    check_req("c1", 1'b0, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    tick();
    // Cycle 2
    imem_rvalid = 1'b0;
    check_id("c2", 1'b1, 32'h0, 32'h0050_0093);
    check("c2.opcode", 32'(id_opcode), 32'h13);
    check_req("c2", 1'b1, 32'h4);
    tick();
    // Cycle 3: bubble between fetches
    check_id("c3", 1'b0, 32'h0, Nop);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0010_0113;
    tick();
    // Cycle 4
    imem_rvalid = 1'b0;
    check_id("c4", 1'b1, 32'h4, 32'h0010_0113);
    check("c4.opcode", 32'(id_opcode), 32'h13);
    check_req("c4", 1'b1, 32'h8);

    // Stall for cycles 4..6; response lands in WAIT during the stall
    stall = 1'b1;
    tick();
    check_id("c5.stall", 1'b1, 32'h4, 32'h0010_0113);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0020_8193;
    tick();
    imem_rvalid = 1'b0;
    check_id("c6.stall", 1'b1, 32'h4, 32'h0010_0113);
    check_req("c6.hold", 1'b0, 32'h0);
    tick();
    check_id("c7.stall", 1'b1, 32'h4, 32'h0010_0113);
    check_req("c7.hold", 1'b0, 32'h0);
    stall = 1'b0;
    tick();
    // Cycle 8: held instruction released, pc advanced by 4
    check_id("c8", 1'b1, 32'h8, 32'h0020_8193);
    check_req("c8", 1'b1, 32'hC);

    // Redirect in REQ: drain the stale response
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    check_req("c9.drain", 1'b0, 32'h0);
    check_id("c9.flush", 1'b0, 32'h0, Nop);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check_req("c10.redir", 1'b1, 32'h100);
    check_id("c10.bubble", 1'b0, 32'h0, Nop);
    tick();

    // Cycle 11: redirect coincides with the response in WAIT
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0033;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    check_req("c12.redir", 1'b1, 32'h200);
    check_id("c12.drop", 1'b0, 32'h0, Nop);

    // Wrap-around at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    tick();
    imem_rvalid = 1'b0;
    check_req("c14.top", 1'b1, 32'hFFFF_FFFC);
    check_id("c14.bubble", 1'b0, 32'h0, Nop);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    tick();
    imem_rvalid = 1'b0;
    check_req("c16.wrap", 1'b1, 32'h0);
    check_id("c16", 1'b1, 32'hFFFF_FFFC, 32'h0000_0013);

    // Reset mid-WAIT with stall held
    stall = 1'b1;
    tick();
    check_id("c17.stall", 1'b1, 32'hFFFF_FFFC, 32'h0000_0013);
    reset = 1'b1;
    tick();
    check_req("c18.rstgate", 1'b0, 32'h0);
    check("c18.valid", 32'(id_valid), 32'h0);
    check("c18.pc", id_pc, 32'h0);
    check("c18.instr", id_instr, Nop);
    reset = 1'b0;
    stall = 1'b0;
    #1;
    check_req("c18.first", 1'b1, 32'h0);
    tick();
    check_req("c19.wait", 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
